hazard_ctrl: RTL and testbench

//  Pipeline hazard sequencer feeding the ID/EX register's stall/flush inputs (data_hazard, PC_hazard, pop_haz,
//  clr_ret_hazard). Detects load-use conflicts between ID and EX, drives multi-cycle flushes after EX redirects,
//  and runs the req/ack handshake with the return-address stack for ret.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_cmp.sv | 26 ++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard sequencer: FSM state encoding, register constants and counter sizing.
package hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2,
    POP      = 2'd3
  } hz_state_e;

  // Down-counter must hold the largest reload value; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = 32'($clog2(m + 1));
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Load-use comparator between the ID source operands and the load sitting in EX.
module hazard_ctrl_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] id_read_addr1,
  input  logic [REG_ADDR_W-1:0] id_read_addr2,
  input  logic                  id_read_en1,
  input  logic                  id_read_en2,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  output logic                  luse
);

  logic hit1;
  logic hit2;
  logic zero_mask;

  assign hit1      = id_read_en1 && (id_read_addr1 == ex_dest_reg);
  assign hit2      = id_read_en2 && (id_read_addr2 == ex_dest_reg);
  assign zero_mask = ZERO_REG_HARDWIRED && (ex_dest_reg == REG_ZERO);
  assign luse      = ex_mem_read && ex_reg_write && (hit1 || hit2) && !zero_mask;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer: load-use stalls, post-redirect flushes and the ret pop handshake with the return stack.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES  = 1,
  parameter int unsigned FLUSH_CYCLES       = 2,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_read_addr1,
  input  logic [REG_ADDR_W-1:0] id_read_addr2,
  input  logic                  id_read_en1,
  input  logic                  id_read_en2,
  input  logic                  id_ret,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic                  ex_redirect,
  input  logic                  stk_pop_ack,
  output logic                  stk_pop_req,
  output logic                  data_hazard,
  output logic                  PC_hazard,
  output logic                  pop_haz,
  output logic                  clr_ret_hazard
);

  localparam int unsigned CNT_W = cnt_width(LOAD_STALL_CYCLES, FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

  hz_state_e        state;
  hz_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             pend_flush;
  logic             pend_flush_n;
  logic             luse;

  hazard_ctrl_cmp #(
    .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
  ) u_cmp (
    .id_read_addr1(id_read_addr1),
    .id_read_addr2(id_read_addr2),
    .id_read_en1  (id_read_en1),
    .id_read_en2  (id_read_en2),
    .ex_dest_reg  (ex_dest_reg),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .luse         (luse)
  );

  // State, counter and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pend_flush     <= 1'b0;
      PC_hazard      <= 1'b0;
      pop_haz        <= 1'b0;
      stk_pop_req    <= 1'b0;
      clr_ret_hazard <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pend_flush     <= pend_flush_n;
      PC_hazard      <= (state_n == FLUSH);
      pop_haz        <= (state_n == POP);
      stk_pop_req    <= (state_n == POP);
      clr_ret_hazard <= (state == POP) && stk_pop_ack;
    end
  end

  // Next state; data_hazard is Mealy so the first bubble lands in the conflict cycle itself.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pend_flush_n = pend_flush;
    data_hazard  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_redirect) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_LOAD;
        end else if (luse) begin
          data_hazard = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = LD_STALL;
            cnt_n   = STALL_LOAD;
          end
        end else if (id_ret) begin
          state_n = POP;
        end
      end
      LD_STALL: begin
        if (ex_redirect) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_LOAD;
        end else begin
          data_hazard = 1'b1;
          if (cnt == '0) state_n = IDLE;
          else           cnt_n   = cnt - CNT_W'(1);
        end
      end
      FLUSH: begin
        if (ex_redirect)     cnt_n   = FLUSH_LOAD;
        else if (cnt == '0)  state_n = IDLE;
        else                 cnt_n   = cnt - CNT_W'(1);
      end
      POP: begin
        // A pop always completes; a redirect seen meanwhile is replayed as a flush afterwards.
        if (stk_pop_ack) begin
          pend_flush_n = 1'b0;
          if (pend_flush || ex_redirect) begin
            state_n = FLUSH;
            cnt_n   = FLUSH_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else if (ex_redirect) begin
          pend_flush_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) data_hazard = 1'b0;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random stimulus for hazard_ctrl (two parameter sets) against a cycle-count reference model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] a1;
    logic [4:0] a2;
    logic       e1;
    logic       e2;
    logic       ret;
    logic [4:0] dest;
    logic       mr;
    logic       rw;
    logic       redir;
    logic       ack;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_read_addr1;
  logic [4:0] id_read_addr2;
  logic       id_read_en1;
  logic       id_read_en2;
  logic       id_ret;
  logic [4:0] ex_dest_reg;
  logic       ex_mem_read;
  logic       ex_reg_write;
  logic       ex_redirect;
  logic       stk_pop_ack;

  logic req[2];
  logic dh[2];
  logic pc[2];
  logic ph[2];
  logic clr[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int unsigned par_l[2] = '{1, 3};
  int unsigned par_f[2] = '{2, 3};

  // Reference model: remaining stall/flush cycles, pop in progress, pending flush, clear pulse due.
  int unsigned stall_left[2];
  int unsigned flush_left[2];
  bit          popping[2];
  bit          pend[2];
  bit          clr_m[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .ZERO_REG_HARDWIRED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .id_read_addr1(id_read_addr1), .id_read_addr2(id_read_addr2),
    .id_read_en1(id_read_en1), .id_read_en2(id_read_en2), .id_ret(id_ret),
    .ex_dest_reg(ex_dest_reg), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_redirect(ex_redirect), .stk_pop_ack(stk_pop_ack),
    .stk_pop_req(req[0]), .data_hazard(dh[0]), .PC_hazard(pc[0]), .pop_haz(ph[0]),
    .clr_ret_hazard(clr[0])
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .ZERO_REG_HARDWIRED(1'b1)) dut3 (
    .clk(clk), .rst(rst),
    .id_read_addr1(id_read_addr1), .id_read_addr2(id_read_addr2),
    .id_read_en1(id_read_en1), .id_read_en2(id_read_en2), .id_ret(id_ret),
    .ex_dest_reg(ex_dest_reg), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_redirect(ex_redirect), .stk_pop_ack(stk_pop_ack),
    .stk_pop_req(req[1]), .data_hazard(dh[1]), .PC_hazard(pc[1]), .pop_haz(ph[1]),
    .clr_ret_hazard(clr[1])
  );

  task automatic chk(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, want);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ld_use(input logic [4:0] d, input logic en1);
    stim_t s;
    s      = '0;
    s.mr   = 1'b1;
    s.rw   = 1'b1;
    s.dest = d;
    s.a1   = d;
    s.e1   = en1;
    s.a2   = 5'd2;
    s.e2   = 1'b1;
    return s;
  endfunction

  function automatic bit model_luse(input stim_t s);
    bit hit;
    hit = (s.e1 && s.a1 == s.dest) || (s.e2 && s.a2 == s.dest);
    return s.mr && s.rw && hit && (s.dest != 5'd0);
  endfunction

  // One clock: drive at negedge, compare before posedge, advance model at posedge.
  task automatic step(input stim_t s);
    bit lu;
    bit e_dh;
    @(negedge clk);
    rst           = s.rst;
    id_read_addr1 = s.a1;
    id_read_addr2 = s.a2;
    id_read_en1   = s.e1;
    id_read_en2   = s.e2;
    id_ret        = s.ret;
    ex_dest_reg   = s.dest;
    ex_mem_read   = s.mr;
    ex_reg_write  = s.rw;
    ex_redirect   = s.redir;
    stk_pop_ack   = s.ack;
    #2;
    lu = model_luse(s);
    for (int k = 0; k < 2; k++) begin
      if (s.rst || flush_left[k] > 0 || popping[k]) e_dh = 1'b0;
      else if (stall_left[k] > 0)                    e_dh = !s.redir;
      else                                           e_dh = lu && !s.redir;
      chk($sformatf("data_hazard[%0d]", k), dh[k], e_dh);
      chk($sformatf("PC_hazard[%0d]", k), pc[k], flush_left[k] > 0);
      chk($sformatf("pop_haz[%0d]", k), ph[k], popping[k]);
      chk($sformatf("stk_pop_req[%0d]", k), req[k], popping[k]);
      chk($sformatf("clr_ret_hazard[%0d]", k), clr[k], clr_m[k]);
      chk($sformatf("mutex[%0d]", k), ($countones({dh[k], pc[k], ph[k]}) <= 1), 1'b1);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (s.rst) begin
        stall_left[k] = 0;
        flush_left[k] = 0;
        popping[k]    = 1'b0;
        pend[k]       = 1'b0;
        clr_m[k]      = 1'b0;
      end else begin
        clr_m[k] = popping[k] && s.ack;
        if (flush_left[k] > 0) begin
          flush_left[k] = s.redir ? par_f[k] : flush_left[k] - 1;
        end else if (popping[k]) begin
          if (s.ack) begin
            popping[k] = 1'b0;
            if (pend[k] || s.redir) flush_left[k] = par_f[k];
            pend[k] = 1'b0;
          end else if (s.redir) begin
            pend[k] = 1'b1;
          end
        end else if (stall_left[k] > 0) begin
          if (s.redir) begin
            stall_left[k] = 0;
            flush_left[k] = par_f[k];
          end else begin
            stall_left[k] = stall_left[k] - 1;
          end
        end else if (s.redir) begin
          flush_left[k] = par_f[k];
        end else if (lu) begin
          stall_left[k] = par_l[k] - 1;
        end else if (s.ret) begin
          popping[k] = 1'b1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(quiet());
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;
    id_read_addr1 = '0; id_read_addr2 = '0; id_read_en1 = 1'b0; id_read_en2 = 1'b0;
    id_ret = 1'b0; ex_dest_reg = '0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_redirect = 1'b0; stk_pop_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; flush_left[k] = 0; popping[k] = 1'b0; pend[k] = 1'b0; clr_m[k] = 1'b0;
    end
    repeat (2) @(posedge clk);

    s = quiet(); s.rst = 1'b1;
    step(s); step(s);
    idle(2);

    // Load-use: enabled source, disabled source, r0 destination
    step(ld_use(5'd5, 1'b1)); idle(3);
    s = ld_use(5'd5, 1'b0); s.a2 = 5'd7; step(s); idle(1);
    step(ld_use(5'd0, 1'b1)); idle(1);

    // Redirect flush, then back-to-back redirects
    s = quiet(); s.redir = 1'b1;
    step(s); chk("t2_pc_t1", pc[0], 1'b1);
    idle(1); chk("t2_pc_t2", pc[0], 1'b1);
    idle(1); chk("t2_pc_t3", pc[0], 1'b0);
    idle(2);
    step(s); step(s); idle(4);

    // ret pop with ack three cycles after the request rises
    s = quiet(); s.ret = 1'b1;
    step(s); chk("t3_req", req[0], 1'b1);
    idle(3);
    s = quiet(); s.ack = 1'b1;
    step(s); chk("t3_clr", clr[0], 1'b1); chk("t3_pop_done", ph[0], 1'b0);
    idle(2);

    // Redirect during pop becomes a flush after the ack
    s = quiet(); s.ret = 1'b1; step(s);
    idle(1);
    s = quiet(); s.redir = 1'b1; step(s);
    idle(1);
    s = quiet(); s.ack = 1'b1;
    step(s); chk("t4_clr", clr[0], 1'b1); chk("t4_pc", pc[0], 1'b1);
    idle(4);

    // Ack and redirect in the same cycle
    s = quiet(); s.ret = 1'b1; step(s);
    idle(1);
    s = quiet(); s.ack = 1'b1; s.redir = 1'b1; step(s);
    idle(4);

    // Load-use with redirect in the same cycle, and redirect aborting a long stall
    s = ld_use(5'd9, 1'b1); s.redir = 1'b1; step(s);
    idle(4);
    step(ld_use(5'd9, 1'b1));
    s = ld_use(5'd9, 1'b1); s.redir = 1'b1; step(s);
    idle(4);

    // Reset during a pop; a late ack must be ignored
    s = quiet(); s.ret = 1'b1; step(s);
    idle(1);
    s = quiet(); s.rst = 1'b1; step(s);
    chk("t6_req", req[0], 1'b0); chk("t6_pop", ph[0], 1'b0);
    idle(1);
    s = quiet(); s.ack = 1'b1; step(s);
    chk("t6_clr", clr[0], 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      s       = quiet();
      s.rst   = ($urandom_range(0, 199) == 0);
      s.a1    = 5'($urandom_range(0, 3));
      s.a2    = 5'($urandom_range(0, 3));
      s.e1    = 1'($urandom_range(0, 1));
      s.e2    = 1'($urandom_range(0, 1));
      s.dest  = 5'($urandom_range(0, 3));
      s.mr    = ($urandom_range(0, 2) != 0);
      s.rw    = ($urandom_range(0, 3) != 0);
      s.ret   = ($urandom_range(0, 7) == 0);
      s.redir = ($urandom_range(0, 9) == 0);
      s.ack   = ($urandom_range(0, 3) == 0);
      step(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
